// File: rtl/filter_seq_ctrl.sv
// Sequencer for a filter datapath: resets and settles the filter, arms on a
// signed rising threshold crossing, then streams a window of filtered samples.
module filter_seq_ctrl #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic [7:0]               window_len,
  input  logic signed [DATA_W-1:0] filt_data,
  output logic                     filt_rst_n,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [15:0]              trig_ts,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CNT_W       = 8;
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] thr_q;
  logic signed [DATA_W-1:0] prev_q;
  logic [CNT_W-1:0]         len_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [15:0]              ts_q;
  logic                     first_q;
  logic                     trig_c;

  // Rising crossing of the latched threshold, signed compare at full width
  assign trig_c = (filt_data >= thr_q) && (prev_q < thr_q);

  // Sequencer state, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      thr_q      <= '0;
      prev_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ts_q       <= '0;
      first_q    <= 1'b0;
      filt_rst_n <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      trig_ts    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      state      <= IDLE;
      cnt_q      <= '0;
      filt_rst_n <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          filt_rst_n <= 1'b0;
          done       <= 1'b0;
          if (start && !abort && (window_len != '0)) begin
            state <= CLEAR;
            thr_q <= threshold;
            len_q <= window_len;
            cnt_q <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == CLEAR_LAST) begin
            state      <= SETTLE;
            cnt_q      <= '0;
            filt_rst_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state   <= ARMED;
            cnt_q   <= '0;
            ts_q    <= '0;
            first_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ARMED: begin
          // First armed cycle only primes prev so a pre-existing high level cannot trigger
          ts_q    <= ts_q + 16'd1;
          prev_q  <= filt_data;
          first_q <= 1'b0;
          if (!first_q && trig_c) begin
            state     <= CAPTURE;
            trig_ts   <= ts_q;
            out_data  <= filt_data;
            out_valid <= 1'b1;
            out_last  <= (len_q == CNT_W'(1));
            cnt_q     <= CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (cnt_q == len_q) begin
            state     <= DONE;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            out_data <= filt_data;
            cnt_q    <= cnt_q + CNT_W'(1);
            out_last <= ((cnt_q + CNT_W'(1)) == len_q);
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          filt_rst_n <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Self-checking bench for filter_seq_ctrl: directed and randomized sequences
// checked cycle by cycle against a timeline model built from sample lists.
module tb_filter_seq_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SETTLE = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     abort;
  logic signed [DATA_W-1:0] threshold;
  logic [7:0]               window_len;
  logic signed [DATA_W-1:0] filt_data;
  logic                     filt_rst_n;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [15:0]              trig_ts;
  logic                     busy;
  logic                     done;

  int checks = 0;
  int errors = 0;
  int dq[$];

  filter_seq_ctrl #(.DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .threshold(threshold), .window_len(window_len), .filt_data(filt_data),
    .filt_rst_n(filt_rst_n), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .trig_ts(trig_ts), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full sequence: start, expected timeline from the sample list, optional abort/reset
  // on capture sample brk_k (mode 0 abort, 1 reset), optional start during ARMED / DONE.
  task automatic run_seq(input int thr, input int len, input int max_armed,
                         input int brk_k, input int brk_mode,
                         input int mid_start, input int mid_thr, input bit start_in_done);
    int  i, brk_c, last_c, idx, k;
    bit  e_busy, e_ov, e_last, e_done, e_frn, c_frn, c_data, c_ts, c_zero;
    logic [15:0] e_data, e_ts;
    i = -1;
    for (int j = 1; j < max_armed && j < dq.size(); j++) begin
      if (dq[j] >= thr && dq[j-1] < thr) begin
        i = j;
        break;
      end
    end
    if (i < 0) brk_c = 11 + max_armed;
    else if (brk_k > 0) brk_c = 11 + i + brk_k;
    else brk_c = -1;
    last_c = (brk_c >= 0) ? brk_c + 3 : 13 + i + len;
    e_ts = (i >= 0) ? 16'(i) : 16'd0;

    threshold  = DATA_W'(thr);
    window_len = 8'(len);
    start      = 1'b1;
    filt_data  = DATA_W'($urandom);
    step();
    start = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      e_busy = 0; e_ov = 0; e_last = 0; e_done = 0; e_frn = 0;
      c_frn = 1; c_data = 0; c_ts = 0; c_zero = 0; e_data = '0;
      if (brk_c >= 0 && c > brk_c) begin
        c_zero = (brk_mode == 1) && (i >= 0);
      end else if (c <= 2) begin
        e_busy = 1;
      end else if (c <= 10) begin
        e_busy = 1; e_frn = 1;
      end else if (i < 0 || c <= 11 + i) begin
        e_busy = 1; e_frn = 1;
      end else if (c <= 11 + i + len) begin
        k = c - 11 - i;
        e_busy = 1; e_frn = 1; e_ov = 1; e_last = (k == len);
        c_data = 1; c_ts = 1; e_data = 16'(dq[i + k - 1]);
      end else if (c == 12 + i + len) begin
        e_done = 1; c_frn = 0; c_ts = 1;
      end

      if (busy !== e_busy) begin errors++; $display("FAIL busy c=%0d got %b exp %b", c, busy, e_busy); end
      checks++;
      if (out_valid !== e_ov) begin errors++; $display("FAIL out_valid c=%0d got %b exp %b", c, out_valid, e_ov); end
      checks++;
      if (out_last !== e_last) begin errors++; $display("FAIL out_last c=%0d got %b exp %b", c, out_last, e_last); end
      checks++;
      if (done !== e_done) begin errors++; $display("FAIL done c=%0d got %b exp %b", c, done, e_done); end
      checks++;
      if (c_frn) begin
        if (filt_rst_n !== e_frn) begin errors++; $display("FAIL filt_rst_n c=%0d got %b exp %b", c, filt_rst_n, e_frn); end
        checks++;
      end
      if (c_data) begin
        if (out_data !== e_data) begin errors++; $display("FAIL out_data c=%0d got %0d exp %0d", c, $signed(out_data), $signed(e_data)); end
        checks++;
      end
      if (c_ts) begin
        if (trig_ts !== e_ts) begin errors++; $display("FAIL trig_ts c=%0d got %0d exp %0d", c, trig_ts, e_ts); end
        checks++;
      end
      if (c_zero) begin
        if (out_data !== '0 || trig_ts !== 16'd0) begin
          errors++; $display("FAIL reset_regs c=%0d out_data %0d trig_ts %0d exp 0 0", c, out_data, trig_ts);
        end
        checks++;
      end

      idx = c - 11;
      filt_data = (idx >= 0 && idx < dq.size()) ? DATA_W'(dq[idx]) : DATA_W'($urandom);
      abort = (brk_mode == 0) && (c == brk_c);
      reset = (brk_mode == 1) && (c == brk_c);
      if (idx == mid_start && (i < 0 || idx < i)) begin
        start = 1'b1; threshold = DATA_W'(mid_thr); window_len = 8'(len + 3);
      end
      if (start_in_done && i >= 0 && c == 12 + i + len) begin
        start = 1'b1; threshold = DATA_W'(thr); window_len = 8'd5;
      end
      step();
      start = 1'b0; abort = 1'b0; reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b0; window_len = 8'd4; threshold = '0;
    filt_data = '0;
    step();
    step();
    reset = 1'b0; start = 1'b0;
    if ({filt_rst_n, out_valid, out_last, busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {filt_rst_n, out_valid, out_last, busy, done});
    end
    checks++;
    if (out_data !== '0 || trig_ts !== 16'd0) begin
      errors++; $display("FAIL reset_data got %0d/%0d exp 0/0", out_data, trig_ts);
    end
    checks++;
    step();
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b exp 0", busy); end
    checks++;
  endtask

  task automatic test_ignored_idle_starts();
    // Zero-length window, then start and abort together: both leave the FSM idle
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; abort = (t == 1); window_len = (t == 0) ? 8'd0 : 8'd4; threshold = '0;
      step();
      start = 1'b0; abort = 1'b0;
      for (int n = 0; n < 3; n++) begin
        if (busy !== 1'b0 || filt_rst_n !== 1'b0) begin
          errors++; $display("FAIL idle_start t=%0d busy %b frn %b exp 0 0", t, busy, filt_rst_n);
        end
        checks++;
        step();
      end
    end
  endtask

  task automatic test_basic();
    dq.delete();
    for (int j = 0; j < 40; j++) dq.push_back(10 * j);
    run_seq(100, 4, 30, 0, 0, -1, 0, 1'b1);
  endtask

  task automatic test_no_prearm();
    dq.delete();
    for (int j = 0; j < 20; j++) dq.push_back(500);
    dq.push_back(50);
    dq.push_back(150);
    for (int j = 0; j < 10; j++) dq.push_back(200 + j);
    run_seq(100, 3, 30, 0, 0, -1, 0, 1'b0);
  endtask

  task automatic test_signed();
    dq.delete();
    dq = '{-10, -6, -5, -1, 3, 7, 9, 11};
    run_seq(-5, 2, 6, 0, 0, -1, 0, 1'b0);
    dq.delete();
    for (int j = 0; j < 12; j++) dq.push_back((j % 2 == 0) ? -3 : -4);
    run_seq(-5, 2, 10, 0, 0, -1, 0, 1'b0);
    dq.delete();
    for (int j = 0; j < 40; j++) dq.push_back(int'($signed(16'($urandom))));
    dq[0] = -32768;
    run_seq(-32768, 2, 30, 0, 0, -1, 0, 1'b0);
  endtask

  task automatic test_abort_capture();
    dq.delete();
    for (int j = 0; j < 40; j++) dq.push_back(10 * j);
    run_seq(100, 4, 30, 2, 0, -1, 0, 1'b0);
  endtask

  task automatic test_reset_capture();
    dq.delete();
    for (int j = 0; j < 40; j++) dq.push_back(10 * j - 50);
    run_seq(0, 6, 30, 3, 1, -1, 0, 1'b0);
  endtask

  task automatic test_start_in_armed();
    dq.delete();
    for (int j = 0; j < 40; j++) dq.push_back(10 * j);
    run_seq(100, 4, 30, 0, 0, 1, 20, 1'b0);
  endtask

  task automatic test_random();
    int thr, len, bk, bm;
    for (int r = 0; r < 8; r++) begin
      thr = int'($urandom_range(200)) - 100;
      len = int'($urandom_range(16, 1));
      dq.delete();
      for (int j = 0; j < 60; j++) dq.push_back(thr + int'($urandom_range(40)) - 20);
      bk = ($urandom_range(3) == 0) ? int'($urandom_range(len, 1)) : 0;
      bm = int'($urandom_range(1));
      run_seq(thr, len, 40, bk, bm, int'($urandom_range(8)), thr - 30, 1'b0);
    end
  endtask

  task automatic test_ts_wrap();
    dq.delete();
    for (int j = 0; j < 65537; j++) dq.push_back(-1);
    for (int j = 0; j < 260; j++) dq.push_back(int'($urandom_range(1000)));
    run_seq(0, 255, 70000, 0, 0, -1, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    threshold = '0; window_len = '0; filt_data = '0;
    test_reset();
    test_ignored_idle_starts();
    test_basic();
    test_no_prearm();
    test_signed();
    test_abort_capture();
    test_reset_capture();
    test_start_in_armed();
    test_random();
    test_ts_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_seq_ctrl.md
FILTER_SEQ_CTRL -- requirements
Module: filter_seq_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 16, filtered-sample width (matches SIZE_FILTER_DATA).
- SETTLE_CYCLES, default 8, filter pipeline flush time in cycles, legal range 1..255.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic rising-edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle request to begin a capture sequence.
- abort, in, 1, cancel any sequence in progress.
- threshold, in, DATA_W, signed trigger level, latched on accepted start.
- window_len, in, 8, number of samples to capture, latched on accepted start.
- filt_data, in, DATA_W, signed filter output, valid every cycle.
- filt_rst_n, out, 1, active-low reset to the filter datapath.
- out_data, out, DATA_W, captured sample.
- out_valid, out, 1, out_data valid.
- out_last, out, 1, final sample of the window.
- trig_ts, out, 16, timestamp of the trigger sample.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, SETTLE, ARMED, CAPTURE and DONE, with every output registered.
REQ-004 IDLE: filt_rst_n=0. Start with window_len!=0 and abort=0 -> CLEAR; latch threshold and window_len. Start with window_len==0 is ignored.
REQ-005 CLEAR: filt_rst_n=0 for exactly 2 cycles, then -> SETTLE.
REQ-006 SETTLE: filt_rst_n=1 for exactly SETTLE_CYCLES cycles, then -> ARMED.
REQ-007 ARMED:
- The 16-bit timestamp counter SHALL be 0 in the first ARMED cycle and increment by 1 per cycle, wrapping 65535->0.
- The first ARMED cycle SHALL only load the prev-sample register; no trigger is evaluated in that cycle.
REQ-008 Trigger condition SHALL be signed filt_data >= threshold AND prev < threshold (rising crossing only). A level already above threshold on ARMED entry SHALL NOT trigger.
REQ-009 On the trigger cycle: latch trig_ts = current counter value, then -> CAPTURE.
REQ-010 CAPTURE output stream:
- out_data in each cycle SHALL equal filt_data from the preceding cycle; the first captured sample is the trigger sample.
- out_valid SHALL be 1 for exactly window_len consecutive cycles, starting the cycle after the trigger.
REQ-011 out_last SHALL be 1 only together with the final out_valid; the following cycle -> DONE.
REQ-012 DONE SHALL last one cycle with done=1 and busy=0, then -> IDLE.
REQ-013 busy SHALL be 1 in CLEAR, SETTLE, ARMED and CAPTURE, and 0 otherwise.
REQ-014 Start while busy=1 or in DONE SHALL be ignored; latched values SHALL NOT change.
REQ-015 Abort in any state other than IDLE SHALL force IDLE on the next edge:
- out_valid and out_last deassert next cycle.
- No done pulse.
- filt_rst_n=0 next cycle.
REQ-016 Abort and start in the same IDLE cycle: abort wins and the FSM stays in IDLE.
REQ-017 ARMED has no timeout; it waits indefinitely until a trigger or an abort.
REQ-018 All comparisons SHALL be signed DATA_W-bit with no extension or saturation; threshold = most-negative value still requires a rising crossing.

Reset
REQ-019 reset=1 at a clock edge SHALL give, next cycle, state IDLE and these outputs:
- filt_rst_n=0
- out_data=0, out_valid=0, out_last=0
- trig_ts=0
- busy=0, done=0
- all counters and the prev register 0
REQ-020 reset SHALL override start and abort, and SHALL terminate a sequence mid-CAPTURE without a done pulse.

Verification
REQ-021 Basic capture:
- Stimulus: SETTLE_CYCLES=8, start at edge 0, window_len=4, threshold=100, filt_data ramp 0,10,20,... from the first ARMED cycle.
- Required: busy=1 from cycle 1; filt_rst_n=0 in cycles 1-2 and 1 from cycle 3; ARMED at cycle 11; trigger on sample 100 at ts=10; out_data=100,110,120,130 with out_last on 130; done one cycle later.
REQ-022 No pre-armed trigger: filt_data held at 500 with threshold=100 -> no trigger; drop to 50 then 150 -> trigger on 150.
REQ-023 Signed crossing: threshold=-5, data -10,-6,-5 -> trigger on -5; data -4 after -3 -> no trigger.
REQ-024 Abort mid-CAPTURE on the 2nd sample -> out_valid=0 next cycle, done never asserted, busy=0, filt_rst_n=0.
REQ-025 Start with window_len=0 -> no state change. Start during ARMED with new threshold -> ignored; the original threshold governs the trigger.
REQ-026 Timestamp wrap: trigger 65537 cycles after ARMED entry -> trig_ts=1; window_len=255 -> exactly 255 out_valid cycles.
